// File: rtl/memory_arbiter_if.sv
// Shared word/RAM-status types and the cache <-> arbiter <-> RAM bundle.
// The `cc` modport is the arbiter's side; `env` is the caches-plus-RAM side.
package mem_arb_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

interface cache_control_if #(parameter int CPUS = 2);
  import mem_arb_pkg::*;
  logic      [CPUS-1:0] iREN, dREN, dWEN, iwait, dwait;
  word_t     [CPUS-1:0] iaddr, daddr, dstore, iload, dload;
  word_t                ramload, ramaddr, ramstore;
  ramstate_t            ramstate;
  logic                 ramREN, ramWEN;
  logic      [CPUS-1:0] ccwrite, cctrans, ccwait, ccinv;
  word_t     [CPUS-1:0] ccsnoopaddr;

  modport cc (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate, ccwrite, cctrans,
    output iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN,
           ccwait, ccinv, ccsnoopaddr
  );
  modport env (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate, ccwrite, cctrans,
    input  iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN,
           ccwait, ccinv, ccsnoopaddr
  );
endinterface

// File: rtl/memory_arbiter.sv
// Grants the single RAM port to one cache request at a time: dcache over icache,
// round-robin per class, with a bounded wait for pending instruction fetches.
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int CPUS       = 2,
  parameter int STARVE_MAX = 4
) (
  input logic            CLK,
  input logic            RST,
  cache_control_if.cc    ccif
);
  localparam int PW = (CPUS > 1) ? $clog2(CPUS) : 1;

  typedef enum logic {IDLE, SERVE} state_t;

  state_t          state_q, state_d;
  logic            cls_q, cls_d;           // 1 = dcache winner
  logic [PW-1:0]   cpu_q, cpu_d, iptr_q, iptr_d, dptr_q, dptr_d;
  logic [3:0]      starve_q, starve_d;

  logic [CPUS-1:0] ireq, dreq, iwait, dwait;
  logic [PW-1:0]   iwin, dwin, nxt;
  logic            pick_i, active, done, ram_ren, ram_wen;
  word_t           ram_addr, ram_store;
  logic            unused_cc;

  // First requester at or after ptr, modulo CPUS.
  function automatic logic [PW-1:0] rr_pick(input logic [CPUS-1:0] req,
                                            input logic [PW-1:0]   ptr);
    logic [PW-1:0] idx;
    rr_pick = ptr;
    for (int k = CPUS - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % CPUS);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  assign ireq   = ccif.iREN;
  assign dreq   = ccif.dREN | ccif.dWEN;
  assign iwin   = rr_pick(ireq, iptr_q);
  assign dwin   = rr_pick(dreq, dptr_q);
  assign pick_i = (|ireq) && ((starve_q == 4'(STARVE_MAX)) || !(|dreq));
  assign nxt    = PW'((int'(cpu_q) + 1) % CPUS);
  assign active = cls_q ? dreq[cpu_q] : ireq[cpu_q];
  assign done   = (state_q == SERVE) && active && (ccif.ramstate == ACCESS);

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    cpu_d     = cpu_q;
    iptr_d    = iptr_q;
    dptr_d    = dptr_q;
    starve_d  = starve_q;
    ram_addr  = '0;
    ram_store = '0;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    iwait     = '1;
    dwait     = '1;
    case (state_q)
      IDLE: begin
        if ((|ireq) || (|dreq)) begin
          state_d = SERVE;
          cls_d   = !pick_i;
          cpu_d   = pick_i ? iwin : dwin;
        end
      end
      SERVE: begin
        if (cls_q) begin
          ram_addr  = ccif.daddr[cpu_q];
          ram_store = ccif.dstore[cpu_q];
          ram_wen   = ccif.dWEN[cpu_q];
          ram_ren   = ccif.dREN[cpu_q] & ~ccif.dWEN[cpu_q];
        end else begin
          ram_addr  = ccif.iaddr[cpu_q];
          ram_ren   = ccif.iREN[cpu_q];
        end
        // A dropped strobe aborts silently; ERROR/BUSY/FREE just hold.
        if (!active) begin
          state_d = IDLE;
        end else if (done) begin
          state_d = IDLE;
          if (cls_q) begin
            dwait[cpu_q] = 1'b0;
            dptr_d       = nxt;
          end else begin
            iwait[cpu_q] = 1'b0;
            iptr_d       = nxt;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!(|ireq))                 starve_d = '0;
    else if (done && !cls_q)      starve_d = '0;
    else if (done && cls_q && (starve_q < 4'(STARVE_MAX)))
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cls_q    <= 1'b0;
      cpu_q    <= '0;
      iptr_q   <= '0;
      dptr_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      cpu_q    <= cpu_d;
      iptr_q   <= iptr_d;
      dptr_q   <= dptr_d;
      starve_q <= starve_d;
    end
  end

  assign ccif.ramaddr     = ram_addr;
  assign ccif.ramstore    = ram_store;
  assign ccif.ramREN      = ram_ren;
  assign ccif.ramWEN      = ram_wen;
  assign ccif.iwait       = iwait;
  assign ccif.dwait       = dwait;
  assign ccif.iload       = {CPUS{ccif.ramload}};
  assign ccif.dload       = {CPUS{ccif.ramload}};
  assign ccif.ccwait      = '0;
  assign ccif.ccinv       = '0;
  assign ccif.ccsnoopaddr = '0;
  assign unused_cc        = ^{ccif.ccwrite, ccif.cctrans};
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: expected grants are queued by the stimulus
// and popped by a monitor whenever a wait bit drops.
module tb_memory_arbiter;
  import mem_arb_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  cache_control_if #(.CPUS(2)) bus ();
  memory_arbiter #(.CPUS(2), .STARVE_MAX(4)) dut (.CLK(CLK), .RST(RST), .ccif(bus));

  typedef struct {
    logic  d;
    int    cpu;
    word_t addr;
    logic  we;
    word_t store;
    word_t load;
  } exp_t;

  exp_t sb[$];
  int   vecs = 0;
  int   errs = 0;
  int   lat  = 0;
  logic [7:0] rcnt = 8'd0;

  // RAM model: ACCESS after `lat` BUSY cycles of a held request.
  assign bus.ramstate = (bus.ramREN || bus.ramWEN) ?
                        ((int'(rcnt) >= lat) ? ACCESS : BUSY) : FREE;
  assign bus.ramload  = (bus.ramaddr == 32'h100) ? 32'hDEADBEEF
                                                 : {bus.ramaddr[15:0], 16'hA5A5};
  always @(posedge CLK)
    if ((bus.ramREN || bus.ramWEN) && bus.ramstate != ACCESS) rcnt <= rcnt + 8'd1;
    else rcnt <= 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic d, input int cpu, input word_t addr, input logic we,
                      input word_t store, input word_t load);
    exp_t e;
    e.d = d; e.cpu = cpu; e.addr = addr; e.we = we; e.store = store; e.load = load;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_acks(input int n);
    int got = 0;
    int c = 0;
    while (got < n && c < 200) begin
      @(negedge CLK);
      c++;
      if (bus.iwait != 2'b11 || bus.dwait != 2'b11) got++;
    end
    if (got < n) begin
      vecs++; errs++;
      $display("FAIL ack_timeout: got %0d acks expected %0d", got, n);
    end
  endtask

  // Monitor: every completion must match the head of the scoreboard.
  always @(negedge CLK) begin
    logic [3:0] ack, eack;
    word_t      ld;
    exp_t       e;
    ack = {~bus.dwait, ~bus.iwait};
    if (!RST && ack != 4'b0) begin
      vecs++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL ack_unexpected: got iwait=%b dwait=%b expected no ack", bus.iwait, bus.dwait);
      end else begin
        e    = sb.pop_front();
        eack = e.d ? (4'b0100 << e.cpu) : (4'b0001 << e.cpu);
        ld   = e.d ? bus.dload[e.cpu] : bus.iload[e.cpu];
        if (ack !== eack || bus.ramaddr !== e.addr || bus.ramWEN !== e.we ||
            bus.ramREN !== !e.we || bus.ramstore !== e.store || ld !== e.load) begin
          errs++;
          $display("FAIL ack_check: got ack=%b addr=%h wen=%b ren=%b store=%h load=%h expected ack=%b addr=%h wen=%b ren=%b store=%h load=%h",
                   ack, bus.ramaddr, bus.ramWEN, bus.ramREN, bus.ramstore, ld,
                   eack, e.addr, e.we, !e.we, e.store, e.load);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iREN = 2'b11; bus.dREN = 2'b11; bus.dWEN = 2'b11;
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
    bus.ccwrite = '0; bus.cctrans = '0;

    // Reset with every request asserted
    @(posedge CLK); @(posedge CLK);
    @(negedge CLK);
    chk("rst_ramREN", 32'(bus.ramREN), 0);
    chk("rst_ramWEN", 32'(bus.ramWEN), 0);
    chk("rst_ramaddr", bus.ramaddr, 0);
    chk("rst_ramstore", bus.ramstore, 0);
    chk("rst_iwait", 32'(bus.iwait), 32'h3);
    chk("rst_dwait", 32'(bus.dwait), 32'h3);
    chk("rst_cc", 32'({bus.ccwait, bus.ccinv}), 0);
    chk("rst_snoop", 32'(|bus.ccsnoopaddr), 0);
    cyc();
    bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
    RST = 1'b0;

    // Single icache read, ACCESS on third SERVE cycle
    cyc();
    lat = 2; bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h100;
    push(1'b0, 0, 32'h100, 1'b0, 32'h0, 32'hDEADBEEF);
    @(negedge CLK);
    @(negedge CLK);
    chk("i_first_addr", bus.ramaddr, 32'h100);
    chk("i_first_ren", 32'(bus.ramREN), 1);
    chk("i_first_wait", 32'(bus.iwait), 32'h3);
    wait_acks(1);
    cyc();
    bus.iREN[0] = 1'b0;
    @(negedge CLK);
    chk("i_one_pulse", 32'(bus.iwait), 32'h3);
    chk("i_idle_ren", 32'(bus.ramREN), 0);

    // dcache write beats a same-cycle icache read; one idle turnaround
    cyc();
    lat = 0;
    bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h200;
    bus.dWEN[1] = 1'b1; bus.daddr[1] = 32'h40; bus.dstore[1] = 32'h12345678;
    push(1'b1, 1, 32'h40, 1'b1, 32'h12345678, 32'h0040A5A5);
    push(1'b0, 0, 32'h200, 1'b0, 32'h0, 32'h0200A5A5);
    @(negedge CLK);
    @(negedge CLK);
    chk("prio_wen", 32'(bus.ramWEN), 1);
    chk("prio_addr", bus.ramaddr, 32'h40);
    chk("prio_store", bus.ramstore, 32'h12345678);
    cyc();
    bus.dWEN[1] = 1'b0; bus.dstore[1] = '0;
    @(negedge CLK);
    chk("prio_turn_ren", 32'({bus.ramREN, bus.ramWEN}), 0);
    @(negedge CLK);
    chk("prio_i_ren", 32'(bus.ramREN), 1);
    chk("prio_i_addr", bus.ramaddr, 32'h200);
    cyc();
    bus.iREN[0] = 1'b0;

    // Round-robin among held dcache reads
    cyc();
    bus.daddr[0] = 32'h10; bus.daddr[1] = 32'h20; bus.dREN = 2'b11;
    push(1'b1, 0, 32'h10, 1'b0, 32'h0, 32'h0010A5A5);
    push(1'b1, 1, 32'h20, 1'b0, 32'h0, 32'h0020A5A5);
    push(1'b1, 0, 32'h10, 1'b0, 32'h0, 32'h0010A5A5);
    push(1'b1, 1, 32'h20, 1'b0, 32'h0, 32'h0020A5A5);
    wait_acks(4);
    cyc();
    bus.dREN = '0;

    // Starvation guard: icache1 wins right after the 4th dcache completion
    cyc();
    bus.dREN = 2'b11; bus.iREN[1] = 1'b1; bus.iaddr[1] = 32'h300;
    push(1'b1, 0, 32'h10, 1'b0, 32'h0, 32'h0010A5A5);
    push(1'b1, 1, 32'h20, 1'b0, 32'h0, 32'h0020A5A5);
    push(1'b1, 0, 32'h10, 1'b0, 32'h0, 32'h0010A5A5);
    push(1'b1, 1, 32'h20, 1'b0, 32'h0, 32'h0020A5A5);
    push(1'b0, 1, 32'h300, 1'b0, 32'h0, 32'h0300A5A5);
    wait_acks(5);
    cyc();
    bus.dREN = '0; bus.iREN = '0;
    @(negedge CLK);
    chk("starve_clear", 32'(dut.starve_q), 0);

    // Abort: strobe dropped while RAM is BUSY
    cyc();
    lat = 10; bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h50;
    @(negedge CLK);
    @(negedge CLK);
    chk("abort_ren_on", 32'(bus.ramREN), 1);
    chk("abort_addr", bus.ramaddr, 32'h50);
    cyc();
    bus.dREN[0] = 1'b0;
    @(negedge CLK);
    chk("abort_ren_drop", 32'(bus.ramREN), 0);
    chk("abort_dwait0", 32'(bus.dwait), 32'h3);
    @(negedge CLK);
    chk("abort_idle_ren", 32'(bus.ramREN), 0);
    chk("abort_dwait1", 32'(bus.dwait), 32'h3);
    chk("abort_state", 32'(dut.state_q), 0);

    // Reset while serving
    cyc();
    bus.dREN[1] = 1'b1; bus.daddr[1] = 32'h70;
    @(negedge CLK);
    @(negedge CLK);
    chk("mrst_ren_on", 32'(bus.ramREN), 1);
    cyc();
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("mrst_ren", 32'({bus.ramREN, bus.ramWEN}), 0);
    chk("mrst_addr", bus.ramaddr, 0);
    chk("mrst_dwait", 32'(bus.dwait), 32'h3);
    cyc();
    RST = 1'b0; bus.dREN = '0;

    repeat (3) @(negedge CLK);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
